// File: rtl/side_ch_arbiter_pkg.sv
// Shared definitions for the side-channel arbiter: source tags, FSM states,
// trailer word layout and the round-robin pick helper.
// Ports: none (package).
package side_ch_arbiter_pkg;

  typedef logic [1:0] src_t;

  // Source tag carried on out_src alongside every word
  localparam src_t SRC_HDR = 2'd0;
  localparam src_t SRC_CSI = 2'd1;
  localparam src_t SRC_EQ  = 2'd2;
  localparam src_t SRC_TRL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_STREAM  = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  // Trailer word layout: {16'h0, eq_sym_cnt[7:0], 6'b0, abort, fcs_ok}
  localparam int TRL_FCS_BIT   = 0;
  localparam int TRL_ABORT_BIT = 1;
  localparam int TRL_SYM_LSB   = 8;
  localparam int TRL_SYM_W     = 8;

  function automatic logic [31:0] trailer_word(input logic [TRL_SYM_W-1:0] sym_cnt,
                                               input logic                 abort_f,
                                               input logic                 fcs_f);
    logic [31:0] w;
    w = '0;
    w[TRL_SYM_LSB +: TRL_SYM_W] = sym_cnt;
    w[TRL_ABORT_BIT]            = abort_f;
    w[TRL_FCS_BIT]              = fcs_f;
    return w;
  endfunction

  // Round-robin pick between the two sources. Returns 1 to select EQ.
  // last_eq is the source that won the previous transfer.
  function automatic logic rr_pick_eq(input logic csi_ne, input logic eq_ne, input logic last_eq);
    logic pick;
    if (csi_ne && eq_ne) pick = !last_eq;
    else                 pick = eq_ne;
    return pick;
  endfunction

endpackage

// File: rtl/side_ch_arbiter_if.sv
// Side-channel output stream bundle (valid/ready, tagged 32-bit words).
// Ports: out_data/out_src/out_last/out_valid driven by master, out_ready by slave.
// Master = arbiter, slave = DMA/capture consumer.
interface side_ch_arbiter_if
  import side_ch_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] out_data;
  src_t                  out_src;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_src,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_src,
    input  out_last,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/side_ch_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on pop_data while !empty.
// Latency: a word pushed at cycle t is visible at t+1. Push while full is ignored
// (caller counts the drop); pop while empty is ignored. flush empties in one cycle.
// Ports: clock, reset, flush, push/push_data, pop/pop_data, full, empty.
module side_ch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/side_ch_arbiter.sv
// Frames CSI and equalizer words into one tagged stream: header, round-robin data, trailer.
// Latency: a source word written at cycle t can be presented at t+1; header the cycle after start.
// Backpressure: out_ready low holds the presented word; sources never stall, full FIFOs drop and count.
// Ports: clock/reset; enable, long_preamble_detected, phase_offset_taken (frame start);
//        csi/csi_valid, equalizer/equalizer_valid, ofdm_symbol_eq_out_pulse, max_eq_sym (sources);
//        fcs_out_strobe/fcs_ok (frame end); side_out (output stream); csi_ovf_cnt, eq_ovf_cnt, busy.
module side_ch_arbiter
  import side_ch_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 6,
  parameter int OVF_CNT_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     long_preamble_detected,
  input  logic [31:0]              phase_offset_taken,
  input  logic [DATA_WIDTH-1:0]    csi,
  input  logic                     csi_valid,
  input  logic [DATA_WIDTH-1:0]    equalizer,
  input  logic                     equalizer_valid,
  input  logic                     ofdm_symbol_eq_out_pulse,
  input  logic [7:0]               max_eq_sym,
  input  logic                     fcs_out_strobe,
  input  logic                     fcs_ok,
  side_ch_arbiter_if.master        side_out,
  output logic [OVF_CNT_WIDTH-1:0] csi_ovf_cnt,
  output logic [OVF_CNT_WIDTH-1:0] eq_ovf_cnt,
  output logic                     busy
);

  state_t state;
  state_t state_nxt;

  logic [31:0]           hdr_reg;
  logic [7:0]            eq_sym_cnt;
  logic                  end_pending;
  logic                  abort;
  logic                  fcs_ok_reg;
  logic                  last_eq;     // source of the previous data transfer (1 = EQ)
  logic                  lock_vld;    // a data word is being held under backpressure
  logic                  lock_eq;     // source of the held word

  logic                  start;
  logic                  in_frame;
  logic                  accept;
  logic                  xfer;

  logic                  csi_wr, csi_push, csi_drop, csi_pop, csi_full, csi_empty;
  logic                  eq_wr, eq_push, eq_drop, eq_pop, eq_full, eq_empty;
  logic [DATA_WIDTH-1:0] csi_dout;
  logic [DATA_WIDTH-1:0] eq_dout;

  logic                  word_vld;
  logic                  grant_eq;

  assign start    = (state == S_IDLE) && long_preamble_detected && enable;
  assign in_frame = (state == S_HDR) || (state == S_STREAM);
  assign accept   = in_frame && !end_pending;
  assign busy     = (state != S_IDLE);

  assign csi_wr   = accept && csi_valid;
  assign csi_push = csi_wr && !csi_full;
  assign csi_drop = csi_wr && csi_full;

  // EQ words beyond the configured symbol budget are discarded silently, not counted as drops
  assign eq_wr    = accept && equalizer_valid && (eq_sym_cnt < max_eq_sym);
  assign eq_push  = eq_wr && !eq_full;
  assign eq_drop  = eq_wr && eq_full;

  side_ch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_csi_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (start),
    .push      (csi_push),
    .push_data (csi),
    .pop       (csi_pop),
    .pop_data  (csi_dout),
    .full      (csi_full),
    .empty     (csi_empty)
  );

  side_ch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_eq_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (start),
    .push      (eq_push),
    .push_data (equalizer),
    .pop       (eq_pop),
    .pop_data  (eq_dout),
    .full      (eq_full),
    .empty     (eq_empty)
  );

  // While a word is stalled the grant is frozen so out_* cannot change under it;
  // a locked source is necessarily non-empty because only a transfer pops it.
  always_comb begin
    word_vld = lock_vld || !csi_empty || !eq_empty;
    if (lock_vld) grant_eq = lock_eq;
    else          grant_eq = rr_pick_eq(!csi_empty, !eq_empty, last_eq);
  end

  always_comb begin
    side_out.out_valid = 1'b0;
    side_out.out_src   = SRC_HDR;
    side_out.out_data  = '0;
    side_out.out_last  = 1'b0;
    unique case (state)
      S_HDR: begin
        side_out.out_valid = 1'b1;
        side_out.out_data  = DATA_WIDTH'(hdr_reg);
      end
      S_STREAM: begin
        if (word_vld) begin
          side_out.out_valid = 1'b1;
          side_out.out_src   = grant_eq ? SRC_EQ : SRC_CSI;
          side_out.out_data  = grant_eq ? eq_dout : csi_dout;
        end
      end
      S_TRAILER: begin
        side_out.out_valid = 1'b1;
        side_out.out_src   = SRC_TRL;
        side_out.out_last  = 1'b1;
        side_out.out_data  = DATA_WIDTH'(trailer_word(eq_sym_cnt, abort, fcs_ok_reg));
      end
      default: ;
    endcase
  end

  assign xfer    = side_out.out_valid && side_out.out_ready;
  assign csi_pop = (state == S_STREAM) && xfer && !grant_eq;
  assign eq_pop  = (state == S_STREAM) && xfer && grant_eq;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_HDR;
      S_HDR:     if (xfer) state_nxt = S_STREAM;
      // Both FIFOs empty implies nothing is locked, so no word is abandoned
      S_STREAM:  if (end_pending && csi_empty && eq_empty) state_nxt = S_TRAILER;
      S_TRAILER: if (xfer) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_reg     <= '0;
      eq_sym_cnt  <= '0;
      end_pending <= 1'b0;
      abort       <= 1'b0;
      fcs_ok_reg  <= 1'b0;
      last_eq     <= 1'b0;
      lock_vld    <= 1'b0;
      lock_eq     <= 1'b0;
    end else if (start) begin
      hdr_reg     <= phase_offset_taken;
      eq_sym_cnt  <= '0;
      end_pending <= 1'b0;
      abort       <= 1'b0;
      fcs_ok_reg  <= 1'b0;
      last_eq     <= 1'b1;  // CSI wins the first tie of the frame
      lock_vld    <= 1'b0;
    end else begin
      if (accept && ofdm_symbol_eq_out_pulse && (eq_sym_cnt != 8'hFF))
        eq_sym_cnt <= eq_sym_cnt + 8'd1;

      // FCS takes priority over a coincident preamble, so abort stays clear
      if (in_frame && fcs_out_strobe) begin
        end_pending <= 1'b1;
        fcs_ok_reg  <= fcs_ok;
      end else if (accept && long_preamble_detected) begin
        end_pending <= 1'b1;
        abort       <= 1'b1;
      end

      if (state == S_STREAM) begin
        if (xfer) begin
          lock_vld <= 1'b0;
          last_eq  <= grant_eq;
        end else if (word_vld) begin
          lock_vld <= 1'b1;
          lock_eq  <= grant_eq;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csi_ovf_cnt <= '0;
      eq_ovf_cnt  <= '0;
    end else begin
      if (csi_drop && (csi_ovf_cnt != '1)) csi_ovf_cnt <= csi_ovf_cnt + OVF_CNT_WIDTH'(1);
      if (eq_drop && (eq_ovf_cnt != '1))   eq_ovf_cnt  <= eq_ovf_cnt + OVF_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_side_ch_arbiter.sv
// Testbench for side_ch_arbiter: cycle vector table plus directed frame sequences.
module tb_side_ch_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        long_preamble_detected;
  logic [31:0] phase_offset_taken;
  logic [31:0] csi;
  logic        csi_valid;
  logic [31:0] equalizer;
  logic        equalizer_valid;
  logic        ofdm_symbol_eq_out_pulse;
  logic [7:0]  max_eq_sym;
  logic        fcs_out_strobe;
  logic        fcs_ok;
  logic [15:0] csi_ovf_cnt;
  logic [15:0] eq_ovf_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  side_ch_arbiter_if #(.DATA_WIDTH(32)) sif ();

  side_ch_arbiter #(
    .DATA_WIDTH      (32),
    .FIFO_DEPTH_LOG2 (6),
    .OVF_CNT_WIDTH   (16)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .enable                   (enable),
    .long_preamble_detected   (long_preamble_detected),
    .phase_offset_taken       (phase_offset_taken),
    .csi                      (csi),
    .csi_valid                (csi_valid),
    .equalizer                (equalizer),
    .equalizer_valid          (equalizer_valid),
    .ofdm_symbol_eq_out_pulse (ofdm_symbol_eq_out_pulse),
    .max_eq_sym               (max_eq_sym),
    .fcs_out_strobe           (fcs_out_strobe),
    .fcs_ok                   (fcs_ok),
    .side_out                 (sif),
    .csi_ovf_cnt              (csi_ovf_cnt),
    .eq_ovf_cnt               (eq_ovf_cnt),
    .busy                     (busy)
  );

  always #5 clock = ~clock;

  // Transfer monitor: valid && ready at the falling edge means the word moves at the next rising edge
  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic        l;
  } beat_t;
  beat_t beats[$];
  bit    mon_en = 1'b0;

  always @(negedge clock) begin
    if (mon_en && sif.out_valid && sif.out_ready)
      beats.push_back('{d: sif.out_data, s: sif.out_src, l: sif.out_last});
  end

  typedef struct {
    logic        pre, en, cv;
    logic [31:0] cd;
    logic        ev;
    logic [31:0] ed;
    logic        sym, fs, fok, rdy;
    logic        vld;
    logic [1:0]  src;
    logic [31:0] dat;
    logic        last, bsy;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  function automatic vec_t mk(input logic pre, input logic en, input logic cv, input logic [31:0] cd,
                              input logic ev, input logic [31:0] ed, input logic sym, input logic fs,
                              input logic fok, input logic rdy, input logic vld, input logic [1:0] src,
                              input logic [31:0] dat, input logic last, input logic bsy);
    vec_t v;
    v.pre = pre; v.en = en; v.cv = cv; v.cd = cd; v.ev = ev; v.ed = ed;
    v.sym = sym; v.fs = fs; v.fok = fok; v.rdy = rdy;
    v.vld = vld; v.src = src; v.dat = dat; v.last = last; v.bsy = bsy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    long_preamble_detected   = 1'b0;
    csi_valid                = 1'b0;
    equalizer_valid          = 1'b0;
    ofdm_symbol_eq_out_pulse = 1'b0;
    fcs_out_strobe           = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    beats.delete();
  endtask

  task automatic wait_trailer(input int budget, input string tag);
    bit seen = 1'b0;
    int n    = 0;
    while (!seen && n < budget) begin
      @(posedge clock);
      n++;
      foreach (beats[i]) if (beats[i].l) seen = 1'b1;
    end
    check({tag, "_trailer_seen"}, 32'(seen), 32'd1);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] hdr,
                             input logic [31:0] cbase, input int nc,
                             input logic [31:0] ebase, input int ne,
                             input logic [31:0] trl);
    int          nh = 0, ncs = 0, neq = 0, nt = 0, bad_last = 0;
    logic [31:0] tdat = '0;
    foreach (beats[i]) begin
      case (beats[i].s)
        2'd0: begin
          nh++;
          check({tag, "_hdr_data"}, beats[i].d, hdr);
        end
        2'd1: begin
          if (ncs < nc) check($sformatf("%s_csi%0d", tag, ncs), beats[i].d, cbase + 32'(ncs));
          ncs++;
        end
        2'd2: begin
          if (neq < ne) check($sformatf("%s_eq%0d", tag, neq), beats[i].d, ebase + 32'(neq));
          neq++;
        end
        default: begin
          nt++;
          tdat = beats[i].d;
        end
      endcase
      if (beats[i].l != (beats[i].s == 2'd3)) bad_last++;
    end
    check({tag, "_hdr_count"}, 32'(nh), 32'd1);
    check({tag, "_csi_count"}, 32'(ncs), 32'(nc));
    check({tag, "_eq_count"}, 32'(neq), 32'(ne));
    check({tag, "_trl_count"}, 32'(nt), 32'd1);
    check({tag, "_trl_data"}, tdat, trl);
    check({tag, "_last_flag_errors"}, 32'(bad_last), 32'd0);
    if (beats.size() > 0) begin
      check({tag, "_first_src"}, 32'(beats[0].s), 32'd0);
      check({tag, "_final_src"}, 32'(beats[beats.size()-1].s), 32'd3);
    end else begin
      check({tag, "_beats_present"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int vcnt;
    enable             = 1'b0;
    phase_offset_taken = '0;
    csi                = '0;
    equalizer          = '0;
    max_eq_sym         = 8'd0;
    fcs_ok             = 1'b0;
    sif.out_ready      = 1'b0;

    // ---------------- reset state ----------------
    do_reset();
    @(negedge clock);
    check("rst_valid", 32'(sif.out_valid), 32'd0);
    check("rst_last", 32'(sif.out_last), 32'd0);
    check("rst_data", sif.out_data, 32'd0);
    check("rst_src", 32'(sif.out_src), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_csi_ovf", 32'(csi_ovf_cnt), 32'd0);
    check("rst_eq_ovf", 32'(eq_ovf_cnt), 32'd0);

    // ---------------- cycle vector table ----------------
    //        pre en cv cd             ev ed             sym fs fok rdy  vld src dat            last busy
    vt[0]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 0, 1,   0, 0, 32'h0,         0, 0);
    vt[1]  = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 0,   0, 0, 32'h0,         0, 0);
    vt[2]  = mk(0, 1, 1, 32'hA0000001,  0, 32'h0,         0, 0, 0, 0,   1, 0, 32'h12345678,  0, 1);
    vt[3]  = mk(0, 1, 1, 32'hA0000002,  1, 32'hE0000001,  0, 0, 0, 0,   1, 0, 32'h12345678,  0, 1);
    vt[4]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 1,   1, 0, 32'h12345678,  0, 1);
    vt[5]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 1,   1, 1, 32'hA0000001,  0, 1);
    vt[6]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 1,   1, 2, 32'hE0000001,  0, 1);
    vt[7]  = mk(0, 1, 1, 32'hA0000003,  0, 32'h0,         0, 0, 0, 0,   1, 1, 32'hA0000002,  0, 1);
    vt[8]  = mk(0, 1, 0, 32'h0,         1, 32'hE0000002,  0, 0, 0, 0,   1, 1, 32'hA0000002,  0, 1);
    vt[9]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         1, 0, 0, 1,   1, 1, 32'hA0000002,  0, 1);
    vt[10] = mk(0, 1, 0, 32'h0,         1, 32'hE0000003,  0, 0, 0, 1,   1, 2, 32'hE0000002,  0, 1);
    vt[11] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 1, 1, 1,   1, 1, 32'hA0000003,  0, 1);
    vt[12] = mk(0, 1, 1, 32'hA0000004,  0, 32'h0,         0, 0, 0, 1,   0, 0, 32'h0,         0, 1);
    vt[13] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 0,   1, 3, 32'h00000101,  1, 1);
    vt[14] = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 1,   1, 3, 32'h00000101,  1, 1);
    vt[15] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 1,   0, 0, 32'h0,         0, 0);
    vt[16] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 1,   0, 0, 32'h0,         0, 0);

    max_eq_sym         = 8'd1;
    phase_offset_taken = 32'h12345678;
    for (int i = 0; i < NV; i++) begin
      cyc();
      long_preamble_detected   = vt[i].pre;
      enable                   = vt[i].en;
      csi_valid                = vt[i].cv;
      csi                      = vt[i].cd;
      equalizer_valid          = vt[i].ev;
      equalizer                = vt[i].ed;
      ofdm_symbol_eq_out_pulse = vt[i].sym;
      fcs_out_strobe           = vt[i].fs;
      fcs_ok                   = vt[i].fok;
      sif.out_ready            = vt[i].rdy;
      @(negedge clock);
      check($sformatf("vec%0d_valid", i), 32'(sif.out_valid), 32'(vt[i].vld));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
      if (vt[i].vld) begin
        check($sformatf("vec%0d_src", i), 32'(sif.out_src), 32'(vt[i].src));
        check($sformatf("vec%0d_data", i), sif.out_data, vt[i].dat);
        check($sformatf("vec%0d_last", i), 32'(sif.out_last), 32'(vt[i].last));
      end
    end
    check("vec_csi_ovf", 32'(csi_ovf_cnt), 32'd0);
    check("vec_eq_ovf", 32'(eq_ovf_cnt), 32'd0);

    // ---------------- full frame: 64 CSI + 2 EQ symbols ----------------
    do_reset();
    enable = 1'b1; max_eq_sym = 8'd2; sif.out_ready = 1'b1; mon_en = 1'b1;
    phase_offset_taken = 32'hCAFE0001;
    cyc(); clr(); long_preamble_detected = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cyc(); clr(); csi_valid = 1'b1; csi = 32'h100 + 32'(i);
    end
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 48; j++) begin
        cyc(); clr(); equalizer_valid = 1'b1; equalizer = 32'h200 + 32'(s * 48 + j);
      end
      cyc(); clr(); ofdm_symbol_eq_out_pulse = 1'b1;
    end
    cyc(); clr(); fcs_out_strobe = 1'b1; fcs_ok = 1'b1;
    cyc(); clr();
    wait_trailer(400, "full");
    check_frame("full", 32'hCAFE0001, 32'h100, 64, 32'h200, 96, 32'h00000201);

    // ---------------- overlapping bursts: strict alternation ----------------
    do_reset();
    max_eq_sym = 8'd1; sif.out_ready = 1'b0;
    phase_offset_taken = 32'hBEEF0002;
    cyc(); clr(); long_preamble_detected = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); clr();
      csi_valid = 1'b1; csi = 32'h500 + 32'(i);
      equalizer_valid = 1'b1; equalizer = 32'h600 + 32'(i);
    end
    cyc(); clr(); sif.out_ready = 1'b1; fcs_out_strobe = 1'b1; fcs_ok = 1'b1;
    cyc(); clr();
    wait_trailer(100, "alt");
    for (int k = 0; k < 8; k++) begin
      if (beats.size() > k + 1)
        check($sformatf("alt_src%0d", k), 32'(beats[k+1].s), (k % 2 == 0) ? 32'd1 : 32'd2);
      else
        check($sformatf("alt_present%0d", k), 32'(beats.size()), 32'(k + 2));
    end
    check_frame("alt", 32'hBEEF0002, 32'h500, 4, 32'h600, 4, 32'h00000001);

    // ---------------- stall with CSI overflow ----------------
    do_reset();
    max_eq_sym = 8'd0; sif.out_ready = 1'b1;
    phase_offset_taken = 32'h0BAD0003;
    cyc(); clr(); long_preamble_detected = 1'b1;
    cyc(); clr();
    bad = 0; vcnt = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(); clr(); sif.out_ready = 1'b0;
      if (k < 80) begin
        csi_valid = 1'b1; csi = 32'h3000 + 32'(k);
      end
      @(negedge clock);
      if (sif.out_valid) begin
        vcnt++;
        if (sif.out_data !== 32'h3000 || sif.out_src !== 2'd1) bad++;
      end
    end
    check("stall_unstable_cycles", 32'(bad), 32'd0);
    check("stall_valid_cycles", 32'(vcnt), 32'd99);
    check("stall_csi_ovf", 32'(csi_ovf_cnt), 32'd16);
    check("stall_eq_ovf", 32'(eq_ovf_cnt), 32'd0);
    cyc(); clr(); sif.out_ready = 1'b1; fcs_out_strobe = 1'b1; fcs_ok = 1'b1;
    cyc(); clr();
    wait_trailer(200, "stall");
    check_frame("stall", 32'h0BAD0003, 32'h3000, 64, 32'h0, 0, 32'h00000001);

    // ---------------- EQ symbol budget ----------------
    do_reset();
    max_eq_sym = 8'd1; sif.out_ready = 1'b1;
    phase_offset_taken = 32'h5A5A0004;
    cyc(); clr(); long_preamble_detected = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 48; j++) begin
        cyc(); clr(); equalizer_valid = 1'b1; equalizer = 32'h700 + 32'(s * 48 + j);
      end
      cyc(); clr(); ofdm_symbol_eq_out_pulse = 1'b1;
    end
    cyc(); clr(); fcs_out_strobe = 1'b1; fcs_ok = 1'b1;
    cyc(); clr();
    wait_trailer(200, "eqcap");
    check_frame("eqcap", 32'h5A5A0004, 32'h0, 0, 32'h700, 48, 32'h00000301);

    // ---------------- abort by second preamble ----------------
    do_reset();
    max_eq_sym = 8'd0; sif.out_ready = 1'b1;
    phase_offset_taken = 32'h11110005;
    cyc(); clr(); long_preamble_detected = 1'b1;
    cyc(); clr();
    for (int i = 0; i < 5; i++) begin
      cyc(); clr(); sif.out_ready = 1'b0; csi_valid = 1'b1; csi = 32'h800 + 32'(i);
    end
    cyc(); clr(); long_preamble_detected = 1'b1; phase_offset_taken = 32'h22220005;
    cyc(); clr(); sif.out_ready = 1'b1;
    wait_trailer(100, "abort");
    check_frame("abort", 32'h11110005, 32'h800, 5, 32'h0, 0, 32'h00000002);
    repeat (4) cyc();
    @(negedge clock);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_valid", 32'(sif.out_valid), 32'd0);

    // ---------------- FCS and preamble coincide ----------------
    do_reset();
    sif.out_ready = 1'b1;
    phase_offset_taken = 32'h33330006;
    cyc(); clr(); long_preamble_detected = 1'b1;
    cyc(); clr();
    cyc(); clr(); csi_valid = 1'b1; csi = 32'h900;
    cyc(); clr(); csi_valid = 1'b1; csi = 32'h901;
    cyc(); clr(); long_preamble_detected = 1'b1; fcs_out_strobe = 1'b1; fcs_ok = 1'b1;
    cyc(); clr();
    wait_trailer(100, "coinc");
    check_frame("coinc", 32'h33330006, 32'h900, 2, 32'h0, 0, 32'h00000001);

    // ---------------- reset mid-frame ----------------
    do_reset();
    mon_en = 1'b0;
    max_eq_sym = 8'd1; sif.out_ready = 1'b0;
    cyc(); clr(); long_preamble_detected = 1'b1;
    for (int i = 0; i < 70; i++) begin
      cyc(); clr();
      csi_valid = 1'b1; csi = 32'(i);
      equalizer_valid = 1'b1; equalizer = 32'(i);
    end
    cyc(); clr();
    @(negedge clock);
    check("midrst_pre_csi_ovf", 32'(csi_ovf_cnt), 32'd6);
    check("midrst_pre_eq_ovf", 32'(eq_ovf_cnt), 32'd6);
    check("midrst_pre_busy", 32'(busy), 32'd1);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; sif.out_ready = 1'b1;
    @(negedge clock);
    check("midrst_valid", 32'(sif.out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_csi_ovf", 32'(csi_ovf_cnt), 32'd0);
    check("midrst_eq_ovf", 32'(eq_ovf_cnt), 32'd0);
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      @(negedge clock);
      if (sif.out_valid) vcnt++;
    end
    check("midrst_no_trailer", 32'(vcnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/side_ch_arbiter.md
Name: side_ch_arbiter

Overview:
Shares one 32-bit side-channel output stream between the two per-packet sources the receiver produces: CSI words and equalizer-output words.
Per packet it emits a framed sequence on a valid/ready stream:
- a header word carrying the taken phase offset,
- round-robin interleaved CSI and equalizer words, each tagged with its source,
- a trailer word with FCS and abort status.
It sits between the receiver core outputs and the side-channel DMA/capture logic. Each source has its own buffer so the core is never stalled.

Parameters:
DATA_WIDTH, 32, width of csi/equalizer/out_data words
FIFO_DEPTH_LOG2, 6, log2 of each per-source FIFO depth (64 words)
OVF_CNT_WIDTH, 16, width of the saturating overflow counters

Ports:
clock  input  1  single clock domain
reset  input  1  synchronous, active-high
enable  input  1  permits start of a new frame
long_preamble_detected  input  1  frame-start pulse
phase_offset_taken  input  32  sampled into the header word
csi  input  DATA_WIDTH  CSI word
csi_valid  input  1  CSI word strobe
equalizer  input  DATA_WIDTH  equalizer output word
equalizer_valid  input  1  equalizer word strobe
ofdm_symbol_eq_out_pulse  input  1  end of one equalized symbol
max_eq_sym  input  8  equalizer symbols captured per frame (0 = none)
fcs_out_strobe  input  1  packet end
fcs_ok  input  1  FCS result, qualified by fcs_out_strobe
out_data  output  DATA_WIDTH  stream data
out_src  output  2  0 = header, 1 = CSI, 2 = EQ, 3 = trailer
out_last  output  1  high on the trailer word
out_valid  output  1  stream valid
out_ready  input  1  stream ready
csi_ovf_cnt  output  OVF_CNT_WIDTH  dropped CSI words
eq_ovf_cnt  output  OVF_CNT_WIDTH  dropped EQ words
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; both FIFOs empty. out_valid, out_last, out_data, out_src, busy, both overflow counters, symbol counter and all flags = 0.
- Handshake: a word transfers when out_valid && out_ready. While out_valid && !out_ready, out_data/out_src/out_last hold stable. out_valid never drops without a transfer.
- FIFOs: show-ahead. A word written at cycle t is presentable on out_* at t+1 at the earliest.
- IDLE:
  - On long_preamble_detected && enable: latch phase_offset_taken into hdr_reg, flush both FIFOs, clear eq_sym_cnt, end_pending, abort, fcs_ok_reg; go to HDR.
  - All other inputs are ignored in IDLE.
- HDR:
  - out_valid=1, out_src=0, out_data=hdr_reg.
  - On transfer, go to STREAM.
  - FIFO writes are already accepted in HDR.
- STREAM:
  - Grant goes to whichever FIFO is non-empty. If both are non-empty, round-robin: grant the source not granted on the last transfer. The pointer initialises to EQ at frame start, so CSI wins the first tie.
  - Grant is evaluated only when no word is pending or on the transfer cycle itself (no grant change mid-stall).
- Write rules, applied in HDR/STREAM while end_pending=0:
  - CSI: pushed on csi_valid.
  - EQ: pushed on equalizer_valid only while eq_sym_cnt < max_eq_sym.
  - Full FIFO: the word is dropped and its counter increments, saturating at all-ones. Counters clear on reset only.
  - eq_sym_cnt increments on ofdm_symbol_eq_out_pulse and saturates at 255.
- Frame end:
  - fcs_out_strobe in HDR/STREAM sets end_pending and latches fcs_ok.
  - long_preamble_detected in HDR/STREAM with end_pending=0 sets end_pending and abort=1. That preamble does not start a new frame.
  - If fcs_out_strobe and long_preamble_detected coincide, fcs wins: abort=0.
  - Once end_pending=1, further writes are ignored.
  - In STREAM with end_pending=1 and both FIFOs empty, go to TRAILER.
- TRAILER:
  - out_valid=1, out_src=3, out_last=1.
  - out_data = {16'h0, eq_sym_cnt[7:0], 6'b0, abort, fcs_ok_reg}.
  - On transfer, go to IDLE. A long_preamble_detected on that same cycle is not taken.
- enable deasserted mid-frame: the current frame completes normally; only new frame starts are gated.
- Reset mid-frame: immediate return to reset state; partial frame is discarded with no trailer.

Decomposition:
- Shared package: source tag constants (SRC_HDR=0, SRC_CSI=1, SRC_EQ=2, SRC_TRL=3), FSM state encoding (S_IDLE, S_HDR, S_STREAM, S_TRAILER) and trailer bit positions.
- One natural sub-module: side_ch_fifo. Synchronous show-ahead FIFO with clock, reset, flush, push, pop, full, empty and DATA_WIDTH/DEPTH_LOG2 parameters, instantiated twice.

Test Plan:
- Preamble, then 64 CSI words, then 2 EQ symbols of 48 words each with max_eq_sym=2, out_ready=1, then fcs_out_strobe with fcs_ok=1 -> header = phase_offset_taken; exactly 64 src=1 and 96 src=2 words in per-source order; trailer 0x00000201 with out_last=1.
- CSI and EQ bursts overlapping with both FIFOs non-empty -> strict alternation 1,2,1,2...; first tie goes to CSI.
- out_ready=0 for 100 cycles while 80 CSI words arrive -> 64 are buffered, csi_ovf_cnt=16; out_data stays stable during the stall; buffered words emerge in order.
- max_eq_sym=1 with 3 EQ symbols arriving -> only the first 48 EQ words are output; trailer eq_sym_cnt field = 3.
- Second long_preamble_detected mid-STREAM, no FCS -> FIFOs drain; trailer bit1=1; return to IDLE; that preamble produces no header.
- fcs_out_strobe and long_preamble_detected in the same cycle -> abort=0; reset asserted mid-frame -> out_valid=0 next cycle, both counters = 0.
